// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel state
// encoding and the stability count for the 100 MHz board clock.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_WAIT   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_WAIT   = 2'd3
  } db_state_e;

  // 10 ms of stability at 100 MHz
  localparam int unsigned CNT_MAX_DEFAULT = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: two-flop synchroniser, stability FSM with a
// saturating qualification counter, and registered level/pulse outputs.
//
// state       | meaning
// ------------+------------------------------------------------------
// LOW_STABLE  | accepted level 0, waiting for s2 to go high
// RISE_WAIT   | s2 high, counting stable cycles before accepting 1
// HIGH_STABLE | accepted level 1, waiting for s2 to go low
// FALL_WAIT   | s2 low, counting stable cycles before accepting 0
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT,
  parameter int unsigned CW      = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_db,
  output logic press,
  output logic release_pulse
);

  localparam logic [CW-1:0] CNT_TC  = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            s1_q, s2_q;
  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Any sample matching the accepted level aborts a wait; a new wait restarts at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (s2_q) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RISE_WAIT: begin
        if (!s2_q) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = HIGH_STABLE;
          db_d    = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!s2_q) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (s2_q) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = LOW_STABLE;
          db_d    = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  assign btn_db        = db_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer; each channel is an independent
// debounce_channel producing a clean level plus press/release pulses.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT,
  parameter int unsigned CW      = $clog2(CNT_MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_db,
  output logic [N-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N-1:0] release_pulse
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX (CNT_MAX),
      .CW      (CW)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_in        (btn_in[i]),
      .btn_db        (btn_db[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (N=4, CNT_MAX=4): vector table,
// directed corner sequences and random stimulus against a run-length model.
module tb_button_debouncer;

  localparam int N       = 4;
  localparam int CNT_MAX = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_db, press, release_pulse;

  always #5 clk = ~clk;

  button_debouncer #(.N(N), .CNT_MAX(CNT_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_db        (btn_db),
    .press         (press),
    .release_pulse (release_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Reference: two-sample input delay, then a level is accepted once the
  // delayed input has differed from it for CNT_MAX+1 consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_db, m_press, m_rel;
  int           m_run [N];

  int press_cnt [N];
  int rel_cnt   [N];
  int press_at  [N];
  int cyc;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] v);
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      if (m_s2[c] != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == CNT_MAX + 1) begin
          m_db[c] = m_s2[c];
          if (m_s2[c]) m_press[c] = 1'b1;
          else         m_rel[c]   = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = v;
  endfunction

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; press_at[c] = -1;
    end
    cyc = 0;
  endtask

  // One clock: drive at negedge, advance model at posedge, check 1 ns later.
  task automatic step(input logic [N-1:0] v, input logic r);
    @(negedge clk);
    btn_in = v;
    reset  = r;
    if (r) model_reset();
    @(posedge clk);
    if (!r) model_edge(v);
    #1;
    check_vec("btn_db",  btn_db,        m_db);
    check_vec("press",   press,         m_press);
    check_vec("release", release_pulse, m_rel);
    check_vec("press_and_release", press & release_pulse, '0);
    for (int c = 0; c < N; c++) begin
      if (press[c]) begin press_cnt[c]++; press_at[c] = cyc; end
      if (release_pulse[c]) rel_cnt[c]++;
    end
    cyc++;
  endtask

  typedef struct {
    logic [N-1:0] in;
    logic [N-1:0] db;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [N-1:0] lvl;
    int           last;

    // Simultaneous press on channels 0 and 3, then simultaneous release.
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 1; i <= 6; i++) tbl[i] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b1001, 4'b1001, 4'b1001, 4'b0000};
    tbl[8] = '{4'b1001, 4'b1001, 4'b0000, 4'b0000};
    for (int i = 9; i <= 14; i++) tbl[i] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b1001};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

    btn_in = '0;
    reset  = 1'b1;
    model_reset();
    #1;
    check_vec("reset_btn_db",  btn_db,        '0);
    check_vec("reset_press",   press,         '0);
    check_vec("reset_release", release_pulse, '0);

    // Reset then idle
    step('0, 1'b1);
    clear_counts();
    repeat (20) step('0, 1'b0);
    check_vec("idle_btn_db", btn_db, '0);
    for (int c = 0; c < N; c++) check_int("idle_pulses", press_cnt[c] + rel_cnt[c], 0);

    // Vector table
    step('0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].in, 1'b0);
      check_vec("tbl_btn_db",  btn_db,        tbl[i].db);
      check_vec("tbl_press",   press,         tbl[i].pr);
      check_vec("tbl_release", release_pulse, tbl[i].rl);
    end

    // Bounce on channel 1: 1,0,1,0,1 then held
    clear_counts();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    last = cyc;
    step(4'b0010, 1'b0);
    repeat (12) step(4'b0010, 1'b0);
    check_int("bounce_press_count", press_cnt[1], 1);
    check_int("bounce_press_cycle", press_at[1], last + CNT_MAX + 2);
    repeat (12) step(4'b0000, 1'b0);
    check_int("bounce_release_count", rel_cnt[1], 1);

    // Short pulse: CNT_MAX cycles rejected, CNT_MAX+1 accepted
    clear_counts();
    repeat (CNT_MAX) step(4'b0100, 1'b0);
    repeat (12) step(4'b0000, 1'b0);
    check_int("short_pulse_press", press_cnt[2], 0);
    check_int("short_pulse_release", rel_cnt[2], 0);
    repeat (CNT_MAX + 1) step(4'b0100, 1'b0);
    repeat (12) step(4'b0000, 1'b0);
    check_int("min_pulse_press", press_cnt[2], 1);
    check_int("min_pulse_release", rel_cnt[2], 1);

    // Reset mid-wait with channel 3 held
    clear_counts();
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    check_vec("midwait_reset_db", btn_db, '0);
    clear_counts();
    repeat (10) step(4'b1000, 1'b0);
    check_int("midwait_press_count", press_cnt[3], 1);
    check_int("midwait_press_cycle", press_at[3], CNT_MAX + 2);
    check_vec("midwait_btn_db", btn_db, 4'b1000);

    // Reset while high: level drops without a release pulse
    clear_counts();
    step(4'b1000, 1'b1);
    check_vec("high_reset_db", btn_db, '0);
    repeat (3) step(4'b0000, 1'b0);
    check_int("high_reset_no_release", rel_cnt[3], 0);

    // Random stimulus, sparse toggles so some levels get accepted
    lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(5) == 0) lvl[c] = ~lvl[c];
      step(lvl, ($urandom_range(499) == 0));
    end
    step(lvl, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
